game_round_ctrl: RTL and testbench
==================================

GAME_ROUND_CTRL -- requirements
Module: game_round_ctrl

Interface
REQ-001 SHALL have parameter START_HP, default 3, initial health of each player (2-bit, 1..3).
REQ-002 SHALL have parameter TURN_TICKS, default 8, number of tick pulses allowed per turn before timeout.
REQ-003 SHALL have port clk  in  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port start  in  1  one-cycle request to begin a match.
REQ-006 SHALL have port tick  in  1  turn-timer strobe, one cycle wide.
REQ-007 SHALL have ports act1_valid, act2_valid  in  1  action offer from player 1 / player 2.
REQ-008 SHALL have ports act1, act2  in  3  action code from game_pkg.
REQ-009 SHALL have ports pos1, pos2  in  3  one-hot player position (player1 100/010/001 = index 0/1/2; player2 001/010/100 = index 0/1/2).
REQ-010 SHALL have ports act1_ack, act2_ack  out  1  one-cycle acceptance of the offered action.
REQ-011 SHALL have ports turn_act1, turn_act2  out  3  resolved actions presented to the player FSMs.
REQ-012 SHALL have port resolve  out  1  one-cycle strobe: player FSMs update on it.
REQ-013 SHALL have ports hp1, hp2  out  2  current health.
REQ-014 SHALL have ports game_over  out  1 and winner  out  2  (00 none, 01 p1, 10 p2, 11 draw).

Function
REQ-015 SHALL implement FSM IDLE -> COLLECT -> RESOLVE -> APPLY -> (COLLECT | DONE); DONE -> IDLE on start.
REQ-016 IDLE: on start, hp1=hp2=START_HP, winner=00, tick counter cleared, go to COLLECT next cycle.
REQ-017 COLLECT: act_valid with no action yet latched SHALL be latched and acked same cycle; further offers in that turn SHALL be ignored (no ack).
REQ-018 COLLECT: when both actions latched, go to RESOLVE next cycle; simultaneous offers both acked in one cycle.
REQ-019 Each tick in COLLECT SHALL increment the turn counter; on reaching TURN_TICKS, missing actions SHALL be forced to wait and FSM goes to RESOLVE.
REQ-020 RESOLVE: decode positions to indices i1,i2; kick hits if i1+i2>=3 and target action != jump; punch hits if i1+i2==4 and target action != wait.
REQ-021 Damage: kick 1, punch 2; both players' hits apply in the same turn; health SHALL saturate at 0 (no wrap).
REQ-022 APPLY: update hp1/hp2, drive turn_act1/2 and pulse resolve for exactly one cycle; resolve latency = 2 cycles after second action latched.
REQ-023 APPLY: if one hp==0 -> DONE, winner = other player; both 0 -> winner 11; else COLLECT, latches and tick counter cleared.
REQ-024 DONE: game_over=1, hp and winner held; acks never asserted; start returns to IDLE flow (REQ-016).
REQ-025 Invalid action codes (110, 111) SHALL be latched as wait.
REQ-026 Invalid (non-one-hot) position SHALL be treated as index 0.

Reset
REQ-027 rst SHALL force IDLE, hp1=hp2=START_HP, winner=00, game_over=0, resolve=0, acks=0, turn_act1/2=wait, counter and latches cleared; overrides start and mid-turn activity.

Configuration
REQ-028 Macro TURN_TIMEOUT_EN: defined -> REQ-019 timeout active; undefined -> tick ignored, COLLECT waits indefinitely for both actions, counter not synthesized.

Structure
REQ-029 game_pkg SHALL hold action codes (kick 000, punch 001, wait 010, jump 011, left 100, right 101), position one-hot constants, FSM state enum, winner codes.
REQ-030 Hit/damage evaluation SHALL be a combinational sub-module hit_resolver (inputs actions, indices; outputs dmg1, dmg2).

Verification
REQ-031 start; p1 kick, p2 wait, i1=2,i2=1 -> resolve pulse, hp2 3->2, hp1 3.
REQ-032 both punch at i1=i2=2 from hp 3 twice -> hp1=hp2=0 after 2nd turn, game_over=1, winner=11.
REQ-033 p1 kick, p2 jump at i1+i2=4 -> no damage; p1 punch, p2 wait -> no damage.
REQ-034 TURN_TIMEOUT_EN, only act1=punch offered, 8 ticks -> turn_act2=wait, resolve pulses; undefined -> no resolve after 20 ticks.
REQ-035 rst asserted with one action latched in COLLECT -> next cycle IDLE, hp=3/3, acks 0, later start begins cleanly.
REQ-036 hp2=1 hit by punch -> hp2=0 (no wrap), winner=01; offers in DONE get no ack.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the game round controller: action codes,
// one-hot position encodings, FSM states, winner codes and small helpers.
package game_pkg;

  typedef enum logic [2:0] {
    ACT_KICK  = 3'b000,
    ACT_PUNCH = 3'b001,
    ACT_WAIT  = 3'b010,
    ACT_JUMP  = 3'b011,
    ACT_LEFT  = 3'b100,
    ACT_RIGHT = 3'b101
  } action_e;

  // Player 1 stands on the left: its index grows as the one-hot bit moves right.
  localparam logic [2:0] POS1_IDX0 = 3'b100;
  localparam logic [2:0] POS1_IDX1 = 3'b010;
  localparam logic [2:0] POS1_IDX2 = 3'b001;
  // Player 2 is mirrored: its index grows as the one-hot bit moves left.
  localparam logic [2:0] POS2_IDX0 = 3'b001;
  localparam logic [2:0] POS2_IDX1 = 3'b010;
  localparam logic [2:0] POS2_IDX2 = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_RESOLVE = 3'd2,
    ST_APPLY   = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10,
    WIN_DRAW = 2'b11
  } winner_e;

  // Codes 110/111 are not actions; they are treated as standing still.
  function automatic action_e sanitize_action(input logic [2:0] code);
    if (code == 3'b110 || code == 3'b111) return ACT_WAIT;
    return action_e'(code);
  endfunction

  // A non-one-hot position falls back to index 0.
  function automatic logic [1:0] decode_pos1(input logic [2:0] pos);
    case (pos)
      POS1_IDX1: return 2'd1;
      POS1_IDX2: return 2'd2;
      default:   return 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] decode_pos2(input logic [2:0] pos);
    case (pos)
      POS2_IDX1: return 2'd1;
      POS2_IDX2: return 2'd2;
      default:   return 2'd0;
    endcase
  endfunction

  // Health never wraps below zero.
  function automatic logic [1:0] sat_sub(input logic [1:0] hp, input logic [1:0] dmg);
    return (hp > dmg) ? hp - dmg : 2'd0;
  endfunction

endpackage

// File: rtl/game_round_ctrl_if.sv
// Player-side handshake bundle: action offers with their acks, and positions.
// The player side (testbench or player logic) is master; the controller is slave.
interface game_round_ctrl_if;
  logic       act1_valid;
  logic [2:0] act1;
  logic       act1_ack;
  logic       act2_valid;
  logic [2:0] act2;
  logic       act2_ack;
  logic [2:0] pos1;
  logic [2:0] pos2;

  modport master (
    output act1_valid, act1, act2_valid, act2, pos1, pos2,
    input  act1_ack, act2_ack
  );

  modport slave (
    input  act1_valid, act1, act2_valid, act2, pos1, pos2,
    output act1_ack, act2_ack
  );
endinterface

// File: rtl/hit_resolver.sv
// Combinational hit/damage evaluation for one turn. A kick lands when the
// players are close enough (i1+i2 >= 3) and the target is not jumping; a
// punch needs point-blank range (i1+i2 == 4) and a target that is not waiting.
module hit_resolver
  import game_pkg::*;
(
  input  action_e    act1,
  input  action_e    act2,
  input  logic [1:0] i1,
  input  logic [1:0] i2,
  output logic [1:0] dmg1,
  output logic [1:0] dmg2
);

  logic [2:0] dist_sum;

  assign dist_sum = {1'b0, i1} + {1'b0, i2};

  // Damage dealt by each attacker to the other; each player plays one action.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    dmg1 = 2'd0;
    dmg2 = 2'd0;
    if (act1 == ACT_KICK && dist_sum >= 3'd3 && act2 != ACT_JUMP) dmg2 = 2'd1;
    if (act1 == ACT_PUNCH && dist_sum == 3'd4 && act2 != ACT_WAIT) dmg2 = 2'd2;
    if (act2 == ACT_KICK && dist_sum >= 3'd3 && act1 != ACT_JUMP) dmg1 = 2'd1;
    if (act2 == ACT_PUNCH && dist_sum == 3'd4 && act1 != ACT_WAIT) dmg1 = 2'd2;
  end

endmodule

// File: rtl/game_round_ctrl.sv
// Round controller for a two-player fighting game: collects one action per
// player per turn, resolves hits, applies damage and detects the end of match.
// Optional macro TURN_TIMEOUT_EN: when defined, a turn times out after
// TURN_TICKS tick strobes and missing actions are forced to wait; when
// undefined, tick is ignored and a turn waits for both actions indefinitely.
module game_round_ctrl
  import game_pkg::*;
#(
  parameter int unsigned START_HP   = 3,
  parameter int unsigned TURN_TICKS = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             tick,
  game_round_ctrl_if.slave act_if,
  output logic [2:0]       turn_act1,
  output logic [2:0]       turn_act2,
  output logic             resolve,
  output logic [1:0]       hp1,
  output logic [1:0]       hp2,
  output logic             game_over,
  output logic [1:0]       winner
);

  localparam logic [1:0] HP_INIT = START_HP[1:0];

  state_e     state_q, state_d;
  action_e    act1_q, act1_d, act2_q, act2_d;
  logic       have1_q, have1_d, have2_q, have2_d;
  logic [1:0] dmg1_q, dmg1_d, dmg2_q, dmg2_d;
  logic [1:0] hp1_q, hp1_d, hp2_q, hp2_d;
  winner_e    winner_q, winner_d;

  logic       accept1, accept2;
  logic       timeout;
  logic [1:0] i1, i2;
  logic [1:0] dmg1_c, dmg2_c;

  // An offer is taken only while collecting and only once per player per turn.
  assign accept1 = (state_q == ST_COLLECT) && act_if.act1_valid && !have1_q;
  assign accept2 = (state_q == ST_COLLECT) && act_if.act2_valid && !have2_q;

  assign i1 = decode_pos1(act_if.pos1);
  assign i2 = decode_pos2(act_if.pos2);

  hit_resolver u_hit_resolver (
    .act1 (act1_q),
    .act2 (act2_q),
    .i1   (i1),
    .i2   (i2),
    .dmg1 (dmg1_c),
    .dmg2 (dmg2_c)
  );

`ifdef TURN_TIMEOUT_EN
  localparam int CNT_W = $clog2(TURN_TICKS + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The turn times out on the tick that brings the count to TURN_TICKS.
  assign timeout = (state_q == ST_COLLECT) && tick && (cnt_q == CNT_W'(TURN_TICKS - 1));

  // Tick counter runs only while collecting and is cleared in every other state.
  always_comb begin
    cnt_d = '0;
    if (state_q == ST_COLLECT) cnt_d = tick ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // Tick counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  logic unused_tick;

  assign unused_tick = tick;
  assign timeout     = 1'b0;
`endif

  // Turn datapath: action latches, damage capture, health and winner update.
  always_comb begin
    act1_d   = act1_q;
    act2_d   = act2_q;
    have1_d  = have1_q;
    have2_d  = have2_q;
    dmg1_d   = dmg1_q;
    dmg2_d   = dmg2_q;
    hp1_d    = hp1_q;
    hp2_d    = hp2_q;
    winner_d = winner_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          hp1_d    = HP_INIT;
          hp2_d    = HP_INIT;
          winner_d = WIN_NONE;
          have1_d  = 1'b0;
          have2_d  = 1'b0;
          act1_d   = ACT_WAIT;
          act2_d   = ACT_WAIT;
        end
      end
      ST_COLLECT: begin
        if (accept1) begin
          act1_d  = sanitize_action(act_if.act1);
          have1_d = 1'b1;
        end
        if (accept2) begin
          act2_d  = sanitize_action(act_if.act2);
          have2_d = 1'b1;
        end
        if (timeout && !have1_d) begin
          act1_d  = ACT_WAIT;
          have1_d = 1'b1;
        end
        if (timeout && !have2_d) begin
          act2_d  = ACT_WAIT;
          have2_d = 1'b1;
        end
      end
      ST_RESOLVE: begin
        dmg1_d = dmg1_c;
        dmg2_d = dmg2_c;
      end
      ST_APPLY: begin
        hp1_d = sat_sub(hp1_q, dmg1_q);
        hp2_d = sat_sub(hp2_q, dmg2_q);
        if (hp1_d == 2'd0 && hp2_d == 2'd0) winner_d = WIN_DRAW;
        else if (hp1_d == 2'd0)             winner_d = WIN_P2;
        else if (hp2_d == 2'd0)             winner_d = WIN_P1;
        else begin
          have1_d = 1'b0;
          have2_d = 1'b0;
        end
      end
      ST_DONE: ;
      default: ;
    endcase
  end

  // Datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      act1_q   <= ACT_WAIT;
      act2_q   <= ACT_WAIT;
      have1_q  <= 1'b0;
      have2_q  <= 1'b0;
      dmg1_q   <= 2'd0;
      dmg2_q   <= 2'd0;
      hp1_q    <= HP_INIT;
      hp2_q    <= HP_INIT;
      winner_q <= WIN_NONE;
    end else begin
      act1_q   <= act1_d;
      act2_q   <= act2_d;
      have1_q  <= have1_d;
      have2_q  <= have2_d;
      dmg1_q   <= dmg1_d;
      dmg2_q   <= dmg2_d;
      hp1_q    <= hp1_d;
      hp2_q    <= hp2_d;
      winner_q <= winner_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (start) state_d = ST_COLLECT;
      ST_COLLECT: if (have1_d && have2_d) state_d = ST_RESOLVE;
      ST_RESOLVE: state_d = ST_APPLY;
      ST_APPLY:   state_d = (hp1_d == 2'd0 || hp2_d == 2'd0) ? ST_DONE : ST_COLLECT;
      ST_DONE:    if (start) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: acks, resolve strobe, presented actions and match status.
  always_comb begin
    act_if.act1_ack = accept1;
    act_if.act2_ack = accept2;
    resolve         = (state_q == ST_APPLY);
    game_over       = (state_q == ST_DONE);
    turn_act1       = ACT_WAIT;
    turn_act2       = ACT_WAIT;
    if (state_q == ST_APPLY) begin
      turn_act1 = act1_q;
      turn_act2 = act2_q;
    end
  end

  assign hp1    = hp1_q;
  assign hp2    = hp2_q;
  assign winner = winner_q;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed testbench for game_round_ctrl: a table of full turns with
// hand-computed health/winner results, plus sequences for split offers,
// repeated offers, mid-turn reset, end-of-match behaviour and the turn timer.
module tb_game_round_ctrl;
  import game_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       tick;
  logic [2:0] turn_act1, turn_act2;
  logic       resolve;
  logic [1:0] hp1, hp2;
  logic       game_over;
  logic [1:0] winner;

  int checks   = 0;
  int failures = 0;

  game_round_ctrl_if bus ();

  game_round_ctrl #(
    .START_HP   (3),
    .TURN_TICKS (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .tick      (tick),
    .act_if    (bus),
    .turn_act1 (turn_act1),
    .turn_act2 (turn_act2),
    .resolve   (resolve),
    .hp1       (hp1),
    .hp2       (hp2),
    .game_over (game_over),
    .winner    (winner)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic       new_match;
    logic [2:0] a1;
    logic [2:0] a2;
    logic [2:0] p1;
    logic [2:0] p2;
    logic [2:0] e_ta1;
    logic [2:0] e_ta2;
    logic [1:0] e_hp1;
    logic [1:0] e_hp2;
    logic [1:0] e_win;
    logic       e_over;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v1, input logic [2:0] a1, input logic v2, input logic [2:0] a2);
    bus.act1_valid = v1;
    bus.act1       = a1;
    bus.act2_valid = v2;
    bus.act2       = a2;
    #1;
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    start = 1'b0;
    tick  = 1'b0;
    offer(1'b0, ACT_WAIT, 1'b0, ACT_WAIT);
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic start_match();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{1'b1, ACT_KICK,  ACT_WAIT,  3'b001, 3'b010, ACT_KICK,  ACT_WAIT,  2'd3, 2'd2, 2'b00, 1'b0};
    vecs[1]  = '{1'b1, ACT_PUNCH, ACT_PUNCH, 3'b001, 3'b100, ACT_PUNCH, ACT_PUNCH, 2'd1, 2'd1, 2'b00, 1'b0};
    vecs[2]  = '{1'b0, ACT_PUNCH, ACT_PUNCH, 3'b001, 3'b100, ACT_PUNCH, ACT_PUNCH, 2'd0, 2'd0, 2'b11, 1'b1};
    vecs[3]  = '{1'b1, ACT_KICK,  ACT_JUMP,  3'b001, 3'b100, ACT_KICK,  ACT_JUMP,  2'd3, 2'd3, 2'b00, 1'b0};
    vecs[4]  = '{1'b0, ACT_PUNCH, ACT_WAIT,  3'b001, 3'b100, ACT_PUNCH, ACT_WAIT,  2'd3, 2'd3, 2'b00, 1'b0};
    vecs[5]  = '{1'b0, ACT_WAIT,  ACT_KICK,  3'b001, 3'b100, ACT_WAIT,  ACT_KICK,  2'd2, 2'd3, 2'b00, 1'b0};
    vecs[6]  = '{1'b0, ACT_LEFT,  ACT_PUNCH, 3'b100, 3'b001, ACT_LEFT,  ACT_PUNCH, 2'd2, 2'd3, 2'b00, 1'b0};
    vecs[7]  = '{1'b0, 3'b110,    ACT_PUNCH, 3'b001, 3'b100, ACT_WAIT,  ACT_PUNCH, 2'd2, 2'd3, 2'b00, 1'b0};
    vecs[8]  = '{1'b0, ACT_KICK,  ACT_RIGHT, 3'b011, 3'b100, ACT_KICK,  ACT_RIGHT, 2'd2, 2'd3, 2'b00, 1'b0};
    vecs[9]  = '{1'b0, ACT_KICK,  3'b111,    3'b001, 3'b010, ACT_KICK,  ACT_WAIT,  2'd2, 2'd2, 2'b00, 1'b0};
    vecs[10] = '{1'b1, ACT_PUNCH, ACT_KICK,  3'b001, 3'b100, ACT_PUNCH, ACT_KICK,  2'd2, 2'd1, 2'b00, 1'b0};
    vecs[11] = '{1'b0, ACT_PUNCH, ACT_KICK,  3'b001, 3'b100, ACT_PUNCH, ACT_KICK,  2'd1, 2'd0, 2'b01, 1'b1};
    vecs[12] = '{1'b1, ACT_LEFT,  ACT_PUNCH, 3'b001, 3'b100, ACT_LEFT,  ACT_PUNCH, 2'd1, 2'd3, 2'b00, 1'b0};
    vecs[13] = '{1'b0, ACT_LEFT,  ACT_PUNCH, 3'b001, 3'b100, ACT_LEFT,  ACT_PUNCH, 2'd0, 2'd3, 2'b10, 1'b1};

    bus.pos1 = 3'b001;
    bus.pos2 = 3'b010;

    // Reset state, with offers pending so the acks are really exercised.
    rst   = 1'b1;
    start = 1'b0;
    tick  = 1'b0;
    offer(1'b1, ACT_KICK, 1'b1, ACT_KICK);
    step();
    step();
    check("rst_hp1", hp1, 2'd3);
    check("rst_hp2", hp2, 2'd3);
    check("rst_winner", winner, 2'b00);
    check("rst_game_over", game_over, 1'b0);
    check("rst_resolve", resolve, 1'b0);
    check("rst_ack1", bus.act1_ack, 1'b0);
    check("rst_ack2", bus.act2_ack, 1'b0);
    check("rst_turn_act1", turn_act1, ACT_WAIT);
    check("rst_turn_act2", turn_act2, ACT_WAIT);
    rst = 1'b0;
    offer(1'b0, ACT_WAIT, 1'b0, ACT_WAIT);

    // Table of full turns: both offers in one cycle, resolve two cycles later.
    for (int v = 0; v < 14; v++) begin
      if (vecs[v].new_match) begin
        do_reset();
        start_match();
      end
      bus.pos1 = vecs[v].p1;
      bus.pos2 = vecs[v].p2;
      offer(1'b1, vecs[v].a1, 1'b1, vecs[v].a2);
      check($sformatf("v%0d_ack1", v), bus.act1_ack, 1'b1);
      check($sformatf("v%0d_ack2", v), bus.act2_ack, 1'b1);
      step();
      offer(1'b0, ACT_WAIT, 1'b0, ACT_WAIT);
      check($sformatf("v%0d_resolve_early", v), resolve, 1'b0);
      step();
      check($sformatf("v%0d_resolve", v), resolve, 1'b1);
      check($sformatf("v%0d_turn_act1", v), turn_act1, vecs[v].e_ta1);
      check($sformatf("v%0d_turn_act2", v), turn_act2, vecs[v].e_ta2);
      step();
      check($sformatf("v%0d_resolve_off", v), resolve, 1'b0);
      check($sformatf("v%0d_hp1", v), hp1, vecs[v].e_hp1);
      check($sformatf("v%0d_hp2", v), hp2, vecs[v].e_hp2);
      check($sformatf("v%0d_winner", v), winner, vecs[v].e_win);
      check($sformatf("v%0d_game_over", v), game_over, vecs[v].e_over);
    end

    // Match ended with player 2 winning: offers ignored, state held.
    offer(1'b1, ACT_KICK, 1'b1, ACT_KICK);
    check("done_ack1", bus.act1_ack, 1'b0);
    check("done_ack2", bus.act2_ack, 1'b0);
    step();
    step();
    step();
    check("done_game_over", game_over, 1'b1);
    check("done_hp1", hp1, 2'd0);
    check("done_hp2", hp2, 2'd3);
    check("done_winner", winner, 2'b10);
    check("done_resolve", resolve, 1'b0);
    offer(1'b0, ACT_WAIT, 1'b0, ACT_WAIT);
    start_match();
    check("restart_game_over", game_over, 1'b0);
    start_match();
    offer(1'b1, ACT_KICK, 1'b0, ACT_WAIT);
    check("restart_ack1", bus.act1_ack, 1'b1);
    check("restart_hp1", hp1, 2'd3);
    check("restart_winner", winner, 2'b00);

    // Split offers: the second offer from player 1 is ignored.
    do_reset();
    start_match();
    bus.pos1 = 3'b001;
    bus.pos2 = 3'b010;
    offer(1'b1, ACT_KICK, 1'b0, ACT_WAIT);
    check("split_ack1_first", bus.act1_ack, 1'b1);
    check("split_ack2_none", bus.act2_ack, 1'b0);
    step();
    offer(1'b1, ACT_PUNCH, 1'b0, ACT_WAIT);
    check("split_ack1_repeat", bus.act1_ack, 1'b0);
    step();
    check("split_no_resolve", resolve, 1'b0);
    offer(1'b0, ACT_WAIT, 1'b1, ACT_WAIT);
    check("split_ack2", bus.act2_ack, 1'b1);
    step();
    offer(1'b0, ACT_WAIT, 1'b0, ACT_WAIT);
    step();
    check("split_resolve", resolve, 1'b1);
    check("split_turn_act1", turn_act1, ACT_KICK);
    step();
    check("split_hp2", hp2, 2'd2);

    // Reset with one action latched mid-turn, then a clean match.
    do_reset();
    start_match();
    offer(1'b1, ACT_PUNCH, 1'b0, ACT_WAIT);
    step();
    rst = 1'b1;
    offer(1'b1, ACT_PUNCH, 1'b1, ACT_PUNCH);
    step();
    rst = 1'b0;
    check("midrst_ack1", bus.act1_ack, 1'b0);
    check("midrst_ack2", bus.act2_ack, 1'b0);
    check("midrst_hp1", hp1, 2'd3);
    check("midrst_hp2", hp2, 2'd3);
    check("midrst_game_over", game_over, 1'b0);
    offer(1'b0, ACT_WAIT, 1'b0, ACT_WAIT);
    start_match();
    bus.pos1 = 3'b001;
    bus.pos2 = 3'b010;
    offer(1'b1, ACT_KICK, 1'b1, ACT_WAIT);
    check("midrst_clean_ack1", bus.act1_ack, 1'b1);
    step();
    offer(1'b0, ACT_WAIT, 1'b0, ACT_WAIT);
    step();
    check("midrst_clean_resolve", resolve, 1'b1);
    step();
    check("midrst_clean_hp1", hp1, 2'd3);
    check("midrst_clean_hp2", hp2, 2'd2);

    // Turn timer: only player 1 offers.
    do_reset();
    start_match();
    bus.pos1 = 3'b001;
    bus.pos2 = 3'b100;
    offer(1'b1, ACT_PUNCH, 1'b0, ACT_WAIT);
    check("tmo_ack1", bus.act1_ack, 1'b1);
    step();
    offer(1'b0, ACT_WAIT, 1'b0, ACT_WAIT);
`ifdef TURN_TIMEOUT_EN
    begin
      int early = 0;
      logic seen = 1'b0;
      for (int t = 0; t < 8; t++) begin
        tick = 1'b1;
        step();
        tick = 1'b0;
        if (resolve) early++;
      end
      check("tmo_no_early_resolve", early, 0);
      for (int c = 0; c < 4 && !seen; c++) begin
        step();
        if (resolve) begin
          seen = 1'b1;
          check("tmo_turn_act1", turn_act1, ACT_PUNCH);
          check("tmo_turn_act2", turn_act2, ACT_WAIT);
        end
      end
      check("tmo_resolve_seen", seen, 1'b1);
    end
`else
    begin
      int pulses = 0;
      for (int t = 0; t < 20; t++) begin
        tick = 1'b1;
        step();
        tick = 1'b0;
        if (resolve) pulses++;
        step();
        if (resolve) pulses++;
      end
      check("notmo_resolve_count", pulses, 0);
      offer(1'b0, ACT_WAIT, 1'b1, ACT_WAIT);
      check("notmo_still_collecting", bus.act2_ack, 1'b1);
      offer(1'b0, ACT_WAIT, 1'b0, ACT_WAIT);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
